// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch PC register feeding a DEPTH-entry {pc, instr} FIFO.
// Optional macro FETCHQ_BYPASS_EN lets an empty queue present imem_data directly.
module fetch_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [N-1:0]           imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   redirect_valid,
    input  logic [N-1:0]           redirect_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [N-1:0]           out_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  pc;
    logic [N-1:0]  mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic empty;
    logic full;
    logic bypass_take;
    logic fifo_pop;
    logic fifo_push;
    logic adv;

    always_comb begin
        empty = (cnt == '0);
        full  = (cnt == CW'(DEPTH));
`ifdef FETCHQ_BYPASS_EN
        // An empty queue exposes the word being fetched right now.
        out_valid   = !reset && !redirect_valid;
        out_instr   = !empty ? mem_instr[rd_ptr] : (out_valid ? imem_data : 32'd0);
        out_pc      = !empty ? mem_pc[rd_ptr]    : (out_valid ? pc : '0);
        bypass_take = empty && out_valid && out_ready;
`else
        out_valid   = !reset && !redirect_valid && !empty;
        out_instr   = empty ? 32'd0 : mem_instr[rd_ptr];
        out_pc      = empty ? '0 : mem_pc[rd_ptr];
        bypass_take = 1'b0;
`endif
        fifo_pop  = out_valid && out_ready && !empty;
        // adv covers both a real push and a bypass consumption; only the former writes.
        adv       = !reset && !redirect_valid && (!full || fifo_pop);
        fifo_push = adv && !bypass_take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_target[N-1:2], 2'b00};
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (adv)       pc     <= pc + N'(4);
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage holds data only; validity is tracked entirely by cnt and the pointers.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= imem_data;
        end
    end

    assign imem_addr = pc;
    assign count     = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (N=64, DEPTH=4).
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.N(64), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] p);
        return p[31:0] ^ p[63:32] ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory model: word is a fixed function of its address.
    assign imem_data = word_at(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b1;
        repeat (5) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || imem_addr !== 64'd0 || count !== 3'd0 ||
                out_pc !== 64'd0 || out_instr !== 32'd0) begin
                errors++;
                $display("FAIL reset_state: valid=%0b addr=%h count=%0d pc=%h instr=%h expected all 0",
                         out_valid, imem_addr, count, out_pc, out_instr);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4*k) || out_instr !== word_at(64'(4*k)) ||
                count !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d: valid=%0b pc=%h instr=%h count=%0d expected 1 %h %h 1",
                         k, out_valid, out_pc, out_instr, count, 64'(4*k), word_at(64'(4*k)));
            end
        end
    endtask

    task automatic test_full();
        reset = 1'b1; tick(); reset = 1'b0; out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            int ec;
            ec = (k < 4) ? k : 4;
            tick();
            checks++;
            if (count !== 3'(ec) || imem_addr !== 64'(4*ec) || out_pc !== 64'd0 ||
                out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d addr=%h pc=%h valid=%0b expected %0d %h 0 1",
                         k, count, imem_addr, out_pc, out_valid, ec, 64'(4*ec));
            end
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if (count !== 3'd4 || out_pc !== 64'd4 || imem_addr !== 64'h14 || out_instr !== word_at(64'd4)) begin
            errors++;
            $display("FAIL full_pop: count=%0d pc=%h addr=%h instr=%h expected 4 4 14 %h",
                     count, out_pc, imem_addr, out_instr, word_at(64'd4));
        end
    endtask

    task automatic test_redirect();
        reset = 1'b1; tick(); reset = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL redir_pre_count: got %0d expected 3", count);
        end
        redirect_valid = 1'b1; redirect_target = 64'h1003; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_valid_forced: got %0b expected 0", out_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || imem_addr !== 64'h1000 || out_valid !== 1'b0 || out_pc !== 64'd0) begin
            errors++;
            $display("FAIL redir_after: count=%0d addr=%h valid=%0b pc=%h expected 0 1000 0 0",
                     count, imem_addr, out_valid, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h1000 || out_instr !== word_at(64'h1000)) begin
            errors++;
            $display("FAIL redir_first: valid=%0b pc=%h instr=%h expected 1 1000 %h",
                     out_valid, out_pc, out_instr, word_at(64'h1000));
        end
        tick();
        checks++;
        if (out_pc !== 64'h1004 || count !== 3'd1) begin
            errors++;
            $display("FAIL redir_second: pc=%h count=%0d expected 1004 1", out_pc, count);
        end
    endtask

    task automatic test_pc_wrap();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_pre: addr=%h count=%0d expected fffffffffffffffc 0", imem_addr, count);
        end
        tick();
        checks++;
        if (imem_addr !== 64'd0 || count !== 3'd1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_push: addr=%h count=%0d pc=%h expected 0 1 fffffffffffffffc",
                     imem_addr, count, out_pc);
        end
        tick();
        redirect_valid = 1'b1; redirect_target = 64'h2000; reset = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 64'd0 || count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_redirect: addr=%h count=%0d valid=%0b expected 0 0 0",
                     imem_addr, count, out_valid);
        end
        reset = 1'b0; redirect_valid = 1'b0;
    endtask

`ifdef FETCHQ_BYPASS_EN
    task automatic test_bypass();
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4*k) || imem_addr !== 64'(4*k) ||
                out_instr !== word_at(64'(4*k)) || count !== 3'd0) begin
                errors++;
                $display("FAIL bypass_%0d: valid=%0b pc=%h addr=%h count=%0d expected 1 %h %h 0",
                         k, out_valid, out_pc, imem_addr, count, 64'(4*k), 64'(4*k));
            end
            tick();
        end
        out_ready = 1'b0;
        tick();
        checks++;
        if (count !== 3'd1 || out_pc !== 64'd16 || imem_addr !== 64'd20) begin
            errors++;
            $display("FAIL bypass_hold: count=%0d pc=%h addr=%h expected 1 10 14", count, out_pc, imem_addr);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        test_bypass();
        test_full_pop_setup_free();
`else
        test_reset();
        test_full();
        test_full_pop();
        test_redirect();
        test_pc_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

`ifdef FETCHQ_BYPASS_EN
    task automatic test_full_pop_setup_free();
        test_pc_wrap();
    endtask
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter N, default 64: width of PC and address paths.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-005 Port imem_addr, output, N: address of the instruction being fetched; equals the fetch PC register.
REQ-006 Port imem_data, input, 32: instruction word, combinationally valid for imem_addr in the same cycle.
REQ-007 Port redirect_valid, input, 1: branch/redirect request.
REQ-008 Port redirect_target, input, N: new fetch PC when redirect_valid is 1.
REQ-009 Port out_valid, output, 1: queue head is valid.
REQ-010 Port out_ready, input, 1: downstream accepts the head.
REQ-011 Port out_instr, output, 32: instruction at the queue head.
REQ-012 Port out_pc, output, N: PC of the queue head.
REQ-013 Port count, output, $clog2(DEPTH)+1: number of occupied entries.

Function
REQ-014 The block SHALL hold a fetch PC register plus a circular FIFO of DEPTH {pc, instr} entries with read/write pointers and an occupancy counter.
REQ-015 Pop SHALL occur on a rising edge when out_valid=1 and out_ready=1, with redirect_valid=0 and reset=0.
REQ-016 Push SHALL occur on a rising edge when redirect_valid=0, reset=0, and either count<DEPTH or a pop occurs in the same cycle; it writes {imem_addr, imem_data} and advances fetch PC by 4.
REQ-017 With no push, fetch PC SHALL hold; the PC increment SHALL wrap modulo 2^N.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; push alone increments count, pop alone decrements it.
REQ-019 Full (count=DEPTH) with no pop: no push, fetch PC holds, imem_addr stable.
REQ-020 Empty (count=0): out_valid=0, and out_instr and out_pc SHALL be 0.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 A redirect SHALL take priority over push and pop: count<=0, both pointers<=0, fetch PC<=redirect_target with bits [1:0] forced to 0, and no push or pop that cycle.
REQ-023 out_valid SHALL be forced to 0 in any cycle where redirect_valid=1.
REQ-024 Latency SHALL be 1 cycle: an instruction pushed at edge k is visible at the head after edge k when the queue was empty.
REQ-025 Program order SHALL be preserved; out_pc of consecutive pops SHALL differ by 4 unless a redirect intervened.

Reset
REQ-026 On reset: fetch PC=0, count=0, pointers=0, out_valid=0, out_instr=0, out_pc=0, imem_addr=0.
REQ-027 Reset SHALL take priority over redirect, push and pop.
REQ-028 Reset asserted mid-operation SHALL discard all entries within the same edge.
REQ-029 On the first edge after reset deasserts, PC 0 SHALL be pushed, and out_valid=1 after that edge.

Configuration
REQ-030 Macro FETCHQ_BYPASS_EN, when defined, SHALL enable a bypass path for the empty queue:
- when count=0 and redirect_valid=0: out_valid=1, out_instr=imem_data, out_pc=imem_addr, combinationally;
- if out_ready=1 in that cycle, the word is consumed directly: fetch PC advances by 4 and no entry is written.
REQ-031 Without FETCHQ_BYPASS_EN, the empty queue SHALL behave per REQ-020 and REQ-024.

Verification
REQ-032 Reset for 5 cycles, imem_data=PC-derived pattern -> during reset out_valid=0, imem_addr=0; after release, out_pc sequence with out_ready=1 is 0,4,8,12...
REQ-033 out_ready=0 for 10 cycles after reset -> count saturates at 4, imem_addr holds at 0x10, out_pc stays 0.
REQ-034 Full queue, out_ready=1 for 1 cycle -> count stays 4, head advances to out_pc=4, imem_addr becomes 0x14.
REQ-035 Queue at count=3, redirect_valid=1 with target 0x1003 -> next cycle count=0, imem_addr=0x1000, out_valid=0; then out_pc 0x1000.
REQ-036 Fetch PC at 0xFFFFFFFFFFFFFFFC, one push -> imem_addr=0; redirect and reset on the same edge -> reset wins, imem_addr=0.
REQ-037 With FETCHQ_BYPASS_EN, empty queue and out_ready=1 -> out_valid=1 the same cycle, out_pc=imem_addr, count stays 0.
